l1_refill_ctrl: RTL and testbench

//  Miss/write handler sitting between the direct-mapped L1 data cache and main memory.

---
 rtl/l1_pkg.sv | 30 +++
 rtl/l1_refill_ctrl.sv | 170 +++++++++++++++++
 tb/tb_l1_refill_ctrl.sv | 356 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : l1_pkg
//  Description : Shared L1 data-cache geometry and the refill controller's
//                state encoding. Imported by l1_refill_ctrl and l1_cache_dm.
//  Contents    : L1_ADDR_WIDTH / L1_DATA_WIDTH / L1_LINE_SIZE  default geometry
//                BYTES_PER_WORD, WORDS_PER_LINE, OFFSET_BITS, WORD_SEL_BITS
//                refill_state_t  {IDLE, RD_REQ, RD_WAIT, WR_REQ}
//  Revision    : 1.0  initial release
// ============================================================================
package l1_pkg;

    localparam int L1_ADDR_WIDTH  = 32;
    localparam int L1_DATA_WIDTH  = 32;
    localparam int L1_LINE_SIZE   = 16;

    localparam int BYTES_PER_WORD = L1_DATA_WIDTH / 8;
    localparam int WORDS_PER_LINE = L1_LINE_SIZE / BYTES_PER_WORD;
    localparam int OFFSET_BITS    = $clog2(L1_LINE_SIZE);
    localparam int WORD_SEL_BITS  = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_REQ  = 2'd1,
        RD_WAIT = 2'd2,
        WR_REQ  = 2'd3
    } refill_state_t;

endpackage : l1_pkg
`default_nettype wire

// File: rtl/l1_refill_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : l1_refill_ctrl
//  Description : Miss/write handler between a direct-mapped L1 data cache and
//                main memory. Read misses refill the whole line one word at a
//                time through the cache fill port; stores are written through
//                (no write-allocate). The CPU is stalled until each operation
//                completes. At most one memory request is outstanding.
//  Ports       : clk, rst (async, active-high)
//                cpu_valid/cpu_we/cpu_addr/cpu_w_data/cpu_byte_en  CPU request
//                cache_hit        lookup result for cpu_addr
//                stall            CPU must hold its request (combinational)
//                fill_en/fill_addr/fill_data/fill_mark_valid  cache fill port
//                mem_req/mem_we/mem_addr/mem_w_data/mem_byte_en  memory request
//                mem_ready        request accepted when mem_req && mem_ready
//                mem_r_valid/mem_r_data  in-order read return
//  Revision    : 1.0  initial release
// ============================================================================
module l1_refill_ctrl
    import l1_pkg::*;
#(
    parameter int ADDR_WIDTH = L1_ADDR_WIDTH,
    parameter int DATA_WIDTH = L1_DATA_WIDTH,
    parameter int LINE_SIZE  = L1_LINE_SIZE
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cpu_valid,
    input  logic                    cpu_we,
    input  logic [ADDR_WIDTH-1:0]   cpu_addr,
    input  logic [DATA_WIDTH-1:0]   cpu_w_data,
    input  logic [DATA_WIDTH/8-1:0] cpu_byte_en,
    input  logic                    cache_hit,
    output logic                    stall,
    output logic                    fill_en,
    output logic [ADDR_WIDTH-1:0]   fill_addr,
    output logic [DATA_WIDTH-1:0]   fill_data,
    output logic                    fill_mark_valid,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_w_data,
    output logic [DATA_WIDTH/8-1:0] mem_byte_en,
    input  logic                    mem_ready,
    input  logic                    mem_r_valid,
    input  logic [DATA_WIDTH-1:0]   mem_r_data
);

    localparam int c_bytes_per_word = DATA_WIDTH / 8;
    localparam int c_words_per_line = LINE_SIZE / c_bytes_per_word;
    localparam int c_cnt_w          = $clog2(c_words_per_line);
    localparam int c_word_lsb       = $clog2(c_bytes_per_word);

    localparam logic [ADDR_WIDTH-1:0] c_line_mask = ~ADDR_WIDTH'(LINE_SIZE - 1);
    localparam logic [ADDR_WIDTH-1:0] c_word_mask = ~ADDR_WIDTH'(c_bytes_per_word - 1);
    localparam logic [c_cnt_w-1:0]    c_last_word = c_cnt_w'(c_words_per_line - 1);

    localparam logic [1:0] c_st_idle    = IDLE;
    localparam logic [1:0] c_st_rd_req  = RD_REQ;
    localparam logic [1:0] c_st_rd_wait = RD_WAIT;
    localparam logic [1:0] c_st_wr_req  = WR_REQ;

    logic [1:0]              r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0]   r_base;
    logic [ADDR_WIDTH-1:0]   r_wr_addr;
    logic [DATA_WIDTH-1:0]   r_wr_data;
    logic [DATA_WIDTH/8-1:0] r_wr_be;
    logic                    r_fill_en;
    logic                    r_fill_mark;
    logic [ADDR_WIDTH-1:0]   r_fill_addr;
    logic [DATA_WIDTH-1:0]   r_fill_data;

    logic [ADDR_WIDTH-1:0]   w_rd_addr;
    logic                    w_idle;
    logic                    w_rd_miss;
    logic                    w_wr_start;

    assign w_idle    = (r_state == c_st_idle);
    assign w_rd_addr = r_base + (ADDR_WIDTH'(r_cnt) << c_word_lsb);

    // The fill port is registered, so the last word lands in the cache at the
    // end of the cycle in which fill_mark_valid is high. The lookup still
    // misses during that cycle; suppress a second refill launch for it.
    assign w_rd_miss  = cpu_valid && !cpu_we && !cache_hit && !r_fill_mark;
    assign w_wr_start = cpu_valid && cpu_we;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_cnt       <= '0;
            r_base      <= '0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_wr_be     <= '0;
            r_fill_en   <= 1'b0;
            r_fill_mark <= 1'b0;
            r_fill_addr <= '0;
            r_fill_data <= '0;
        end else begin
            r_fill_en   <= 1'b0;
            r_fill_mark <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_wr_start) begin
                        r_wr_addr <= cpu_addr & c_word_mask;
                        r_wr_data <= cpu_w_data;
                        r_wr_be   <= cpu_byte_en;
                        r_state   <= c_st_wr_req;
                    end else if (w_rd_miss) begin
                        r_base  <= cpu_addr & c_line_mask;
                        r_cnt   <= '0;
                        r_state <= c_st_rd_req;
                    end
                end
                c_st_rd_req: begin
                    if (mem_ready) begin
                        r_state <= c_st_rd_wait;
                    end
                end
                c_st_rd_wait: begin
                    if (mem_r_valid) begin
                        r_fill_en   <= 1'b1;
                        r_fill_addr <= w_rd_addr;
                        r_fill_data <= mem_r_data;
                        if (r_cnt == c_last_word) begin
                            // Explicit wrap so the next refill starts at word 0
                            // regardless of line geometry.
                            r_fill_mark <= 1'b1;
                            r_cnt       <= '0;
                            r_state     <= c_st_idle;
                        end else begin
                            r_cnt   <= r_cnt + c_cnt_w'(1);
                            r_state <= c_st_rd_req;
                        end
                    end
                end
                c_st_wr_req: begin
                    if (mem_ready) begin
                        r_state <= c_st_idle;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

    // Memory request fields are decoded from registers only, so they move on
    // clock edges and stay stable while a request waits for mem_ready.
    assign mem_req     = (r_state == c_st_rd_req) || (r_state == c_st_wr_req);
    assign mem_we      = (r_state == c_st_wr_req);
    assign mem_addr    = (r_state == c_st_rd_req) ? w_rd_addr :
                         (r_state == c_st_wr_req) ? r_wr_addr : '0;
    assign mem_w_data  = mem_we ? r_wr_data : '0;
    assign mem_byte_en = mem_we ? r_wr_be   : '0;

    assign fill_en         = r_fill_en;
    assign fill_addr       = r_fill_addr;
    assign fill_data       = r_fill_data;
    assign fill_mark_valid = r_fill_mark;

    // A store is released in the same cycle memory accepts it.
    assign stall = (w_idle && cpu_valid && (cpu_we || !cache_hit))
                || (r_state == c_st_rd_req) || (r_state == c_st_rd_wait)
                || ((r_state == c_st_wr_req) && !mem_ready);

endmodule : l1_refill_ctrl
`default_nettype wire

// File: tb/tb_l1_refill_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_l1_refill_ctrl
//  Description : Self-checking bench for l1_refill_ctrl. A transaction-level
//                model (expected memory request queue, expected fill queue,
//                tag/valid array, in-order memory with random latency) is
//                compared against the DUT every cycle; directed scenarios pin
//                the model with literal expectations, then random traffic runs.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_l1_refill_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_valid, cpu_we, cache_hit;
    logic [31:0] cpu_addr, cpu_w_data;
    logic [3:0]  cpu_byte_en;
    logic        stall, fill_en, fill_mark_valid;
    logic [31:0] fill_addr, fill_data;
    logic        mem_req, mem_we, mem_ready, mem_r_valid;
    logic [31:0] mem_addr, mem_w_data, mem_r_data;
    logic [3:0]  mem_byte_en;

    l1_refill_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .LINE_SIZE(16)) dut (
        .clk(clk), .rst(rst),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_w_data(cpu_w_data), .cpu_byte_en(cpu_byte_en), .cache_hit(cache_hit),
        .stall(stall),
        .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
        .fill_mark_valid(fill_mark_valid),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_w_data(mem_w_data), .mem_byte_en(mem_byte_en),
        .mem_ready(mem_ready), .mem_r_valid(mem_r_valid), .mem_r_data(mem_r_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic we; logic [31:0] addr; logic [31:0] data; logic [3:0] be; } memop_t;
    typedef struct { logic [31:0] addr; int due; } rd_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic mark; } fill_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    memop_t      exp_mem[$];
    rd_t         pend[$];
    fill_t       exp_fill[$];
    logic [31:0] acc_log[$];

    logic        c_valid[8];
    logic [24:0] c_tag[8];

    int  lat_fix = 0, ready_low_n = 0;
    bit  ready_rand = 0, spur_en = 0, force_spur = 0;
    bit  req_active = 0, req_miss = 0;
    int  req_start = 0, mark_cyc = -10, wr_acc_cyc = -10;
    int  fill_cnt = 0, mark_cnt = 0;
    logic [31:0] last_mark_addr = '0, last_wdata = '0;
    logic [3:0]  last_wbe = '0;
    bit  s_done = 0, prev_wait = 0;
    logic s_stall;
    memop_t prev_op;

    function automatic logic [31:0] memfn(logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    function automatic bit model_hit(logic [31:0] a);
        return c_valid[a[6:4]] && (c_tag[a[6:4]] == a[31:7]);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(string name, string what);
        total++;
        bad++;
        $display("FAIL %s: %s (cycle %0d)", name, what, cyc);
    endtask

    // One clock cycle: called at a negedge with CPU inputs already set.
    task automatic tick();
        bit real_rv;
        bit acc;
        cache_hit = model_hit(cpu_addr);
        if (ready_low_n > 0 && mem_req) begin
            mem_ready = 1'b0;
            ready_low_n--;
        end else begin
            mem_ready = ready_rand ? ($urandom_range(3) != 0) : 1'b1;
        end
        real_rv     = 1'b0;
        mem_r_valid = 1'b0;
        mem_r_data  = $urandom;
        if (pend.size() > 0) begin
            if (pend[0].due <= cyc) begin
                real_rv     = 1'b1;
                mem_r_valid = 1'b1;
                mem_r_data  = memfn(pend[0].addr);
            end
        end else if (force_spur || (spur_en && $urandom_range(7) == 0)) begin
            mem_r_valid = 1'b1;
            mem_r_data  = force_spur ? 32'h55 : $urandom;
        end
        force_spur = 1'b0;
        #1;
        s_stall = stall;
        s_done  = 1'b0;
        acc     = mem_req && mem_ready;

        if (cpu_valid && !req_active) begin
            req_active = 1'b1;
            req_start  = cyc;
            req_miss   = !cpu_we && !cache_hit;
            chk("stall_on_issue", 32'(stall), 32'(cpu_we || !cache_hit));
            if (cpu_we) begin
                exp_mem.push_back('{1'b1, cpu_addr & ~32'h3, cpu_w_data, cpu_byte_en});
            end else if (req_miss) begin
                for (int i = 0; i < 4; i++) begin
                    logic [31:0] a;
                    a = (cpu_addr & ~32'hF) + 32'(i * 4);
                    exp_mem.push_back('{1'b0, a, 32'h0, 4'h0});
                    exp_fill.push_back('{a, memfn(a), (i == 3)});
                end
            end
        end

        if (prev_wait) begin
            chk("req_hold", 32'(mem_req), 32'd1);
            chk("req_hold_addr", mem_addr, prev_op.addr);
            chk("req_hold_data", mem_w_data, prev_op.data);
            chk("req_hold_be", 32'(mem_byte_en), 32'(prev_op.be));
        end
        if (mem_req) chk("one_outstanding", 32'(pend.size()), 32'd0);

        if (acc) begin
            if (exp_mem.size() == 0) begin
                fail_now("unexpected_req", $sformatf("actual addr=%h we=%b required=no request", mem_addr, mem_we));
            end else begin
                memop_t e;
                e = exp_mem.pop_front();
                chk("req_we", 32'(mem_we), 32'(e.we));
                chk("req_addr", mem_addr, e.addr);
                if (e.we) begin
                    chk("req_wdata", mem_w_data, e.data);
                    chk("req_be", 32'(mem_byte_en), 32'(e.be));
                end
            end
            if (!mem_we) begin
                pend.push_back('{mem_addr, cyc + ((lat_fix > 0) ? lat_fix : int'($urandom_range(1, 4)))});
            end else begin
                wr_acc_cyc = cyc;
                last_wdata = mem_w_data;
                last_wbe   = mem_byte_en;
            end
            acc_log.push_back(mem_addr);
        end
        prev_wait = mem_req && !mem_ready;
        prev_op   = '{mem_we, mem_addr, mem_w_data, mem_byte_en};
        if (real_rv) void'(pend.pop_front());

        if (fill_en) begin
            fill_cnt++;
            if (exp_fill.size() == 0) begin
                fail_now("unexpected_fill", $sformatf("actual addr=%h required=no fill", fill_addr));
            end else begin
                fill_t f;
                f = exp_fill.pop_front();
                chk("fill_addr", fill_addr, f.addr);
                chk("fill_data", fill_data, f.data);
                chk("fill_mark", 32'(fill_mark_valid), 32'(f.mark));
            end
            if (fill_mark_valid) begin
                c_valid[fill_addr[6:4]] = 1'b1;
                c_tag[fill_addr[6:4]]   = fill_addr[31:7];
                mark_cyc       = cyc;
                mark_cnt++;
                last_mark_addr = fill_addr;
            end
        end else if (fill_mark_valid) begin
            fail_now("mark_without_fill", "actual fill_mark_valid=1 required=0");
        end

        if (req_active && cpu_valid && cpu_we && acc && mem_we)
            chk("store_release_on_accept", 32'(stall), 32'd0);
        if (req_active && cpu_valid && !stall) begin
            if (cpu_we)        chk("store_done_cycle", 32'(wr_acc_cyc), 32'(cyc));
            else if (req_miss) chk("refill_done_cycle", 32'(mark_cyc), 32'(cyc - 1));
            else               chk("hit_zero_cycle", 32'(cyc), 32'(req_start));
            req_active = 1'b0;
            s_done     = 1'b1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_op(bit we, logic [31:0] a, logic [31:0] d, logic [3:0] be);
        int n = 0;
        cpu_valid   = 1'b1;
        cpu_we      = we;
        cpu_addr    = a;
        cpu_w_data  = d;
        cpu_byte_en = be;
        do begin
            tick();
            n++;
        end while (!s_done && n < 200);
        if (!s_done) begin
            fail_now("op_timeout", $sformatf("actual=no completion in 200 cycles required=completion addr=%h", a));
            req_active = 1'b0;
        end
    endtask

    initial begin
        int s, f0, m0, n;
        for (int i = 0; i < 8; i++) begin
            c_valid[i] = 1'b0;
            c_tag[i]   = '0;
        end
        rst = 1'b1;
        cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_w_data = '0; cpu_byte_en = '0;
        cache_hit = 1'b0; mem_ready = 1'b0; mem_r_valid = 1'b0; mem_r_data = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset_stall", 32'(stall), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_fill_en", 32'(fill_en), 32'd0);
        chk("reset_mark", 32'(fill_mark_valid), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Load miss at 0x1234, latency 3, memory always ready.
        acc_log.delete(); f0 = fill_cnt; m0 = mark_cnt; lat_fix = 3; s = cyc;
        do_op(1'b0, 32'h0000_1234, 32'h0, 4'h0);
        chk("t1_latency", 32'(cyc - 1 - s), 32'd18);
        chk("t1_nreads", 32'(acc_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < acc_log.size(); i++)
            chk("t1_read_addr", acc_log[i], 32'h0000_1230 + 32'(4 * i));
        chk("t1_nfills", 32'(fill_cnt - f0), 32'd4);
        chk("t1_nmarks", 32'(mark_cnt - m0), 32'd1);
        chk("t1_mark_addr", last_mark_addr, 32'h0000_123C);

        // Store with memory not ready for two cycles.
        acc_log.delete(); ready_low_n = 2; s = cyc;
        do_op(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b0011);
        chk("t2_latency", 32'(cyc - 1 - s), 32'd3);
        chk("t2_nreq", 32'(acc_log.size()), 32'd1);
        chk("t2_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("t2_be", 32'(last_wbe), 32'h3);
        if (acc_log.size() > 0) chk("t2_addr", acc_log[0], 32'h0000_0040);

        // Load hit on the line just filled.
        acc_log.delete(); f0 = fill_cnt; s = cyc;
        do_op(1'b0, 32'h0000_1238, 32'h0, 4'h0);
        chk("t3_latency", 32'(cyc - 1 - s), 32'd0);
        chk("t3_nreq", 32'(acc_log.size()), 32'd0);
        chk("t3_nfills", 32'(fill_cnt - f0), 32'd0);
        cpu_valid = 1'b0;

        // Reset while waiting for word 2 of a refill.
        acc_log.delete(); f0 = fill_cnt; m0 = mark_cnt; lat_fix = 5; n = 0;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_2000;
        while (acc_log.size() < 3 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_now("t4_timeout", "actual=fewer than 3 reads required=3 reads");
        chk("t4_fills_before", 32'(fill_cnt - f0), 32'd2);
        cpu_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("t4_rst_mem_req", 32'(mem_req), 32'd0);
        chk("t4_rst_fill_en", 32'(fill_en), 32'd0);
        chk("t4_rst_mark", 32'(fill_mark_valid), 32'd0);
        chk("t4_rst_stall", 32'(stall), 32'd0);
        chk("t4_no_mark", 32'(mark_cnt - m0), 32'd0);
        pend.delete(); exp_mem.delete(); exp_fill.delete();
        req_active = 1'b0; prev_wait = 1'b0;
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        lat_fix = 2;
        cpu_valid = 1'b1;
        tick();
        chk("t4_remiss_stall", 32'(s_stall), 32'd1);
        do_op(1'b0, 32'h0000_2000, 32'h0, 4'h0);
        chk("t4_refill_marks", 32'(mark_cnt - m0), 32'd1);
        cpu_valid = 1'b0;

        // Spurious read data while idle.
        acc_log.delete(); f0 = fill_cnt; force_spur = 1'b1;
        tick();
        tick();
        chk("t5_nfills", 32'(fill_cnt - f0), 32'd0);
        chk("t5_nreq", 32'(acc_log.size()), 32'd0);
        s = cyc;
        do_op(1'b0, 32'h0000_1230, 32'h0, 4'h0);
        chk("t5_idle_hit", 32'(cyc - 1 - s), 32'd0);

        // Back-to-back load miss then store, random memory handshake.
        ready_rand = 1'b1; lat_fix = 0; acc_log.delete();
        do_op(1'b0, 32'h0000_3004, 32'h0, 4'h0);
        do_op(1'b1, 32'h0000_3008, 32'h1234_5678, 4'hF);
        chk("t6_order", 32'(wr_acc_cyc > mark_cyc), 32'd1);
        chk("t6_nreq", 32'(acc_log.size()), 32'd5);
        if (acc_log.size() == 5) chk("t6_waddr", acc_log[4], 32'h0000_3008);
        cpu_valid = 1'b0;

        // CPU drops its request mid-refill; the refill still completes.
        m0 = mark_cnt; n = 0;
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0500;
        tick();
        cpu_valid = 1'b0;
        while (mark_cnt == m0 && n < 200) begin
            tick();
            n++;
        end
        if (n >= 200) fail_now("t7_timeout", "actual=no fill_mark_valid required=refill completes");
        chk("t7_mark_addr", last_mark_addr, 32'h0000_050C);
        cpu_valid = 1'b1;
        tick();
        chk("t7_done", 32'(s_done), 32'd1);
        chk("t7_stall", 32'(s_stall), 32'd0);
        cpu_valid = 1'b0;

        // Random traffic.
        spur_en = 1'b1;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(3) == 0) begin
                cpu_valid = 1'b0;
                tick();
            end else begin
                do_op(1'($urandom_range(1)), 32'($urandom_range(0, 'h3FF)), 32'($urandom),
                      4'($urandom_range(1, 15)));
            end
        end
        cpu_valid = 1'b0;
        repeat (8) tick();
        chk("end_exp_mem_empty", 32'(exp_mem.size()), 32'd0);
        chk("end_exp_fill_empty", 32'(exp_fill.size()), 32'd0);
        chk("end_pend_empty", 32'(pend.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_l1_refill_ctrl
`default_nettype wire
